adder_vector_checker: RTL and testbench
=======================================

// Module: adder_vector_checker
// PURPOSE
//  Synthesizable self-test initiator for the WIDTH-bit ripple-carry adder under test (full_adder /
//  incorr_full_adder chains). Drives operand vectors A, B, CIN into the external adder and waits a
//  settle time. Samples SUM and compares it against a golden A+B+CIN. Counts mismatches and captures
//  the first failing vector. Sits beside the adder in place of the plusarg-driven bench, so fault
//  injection is detected in hardware.
// PARAMETERS
//  WIDTH          8             operand width; SUM is WIDTH+1 bits; legal range 2..15
//  SETTLE_CYCLES  2             cycles between operand drive and SUM sample; legal range >=1
//  CNT_W          16            width of vector-count and error-count registers
//  SEED           32'hACE1_1234 LFSR reset/restart seed; must be nonzero
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        synchronous, active-low reset
//  start           in   1        begin a run; sampled only in IDLE or DONE
//  num_vectors     in   CNT_W    number of vectors in the run; latched on start
//  dut_a           out  WIDTH    operand A to the adder
//  dut_b           out  WIDTH    operand B to the adder
//  dut_cin         out  1        carry-in to the adder
//  dut_sum         in   WIDTH+1  adder result {cout, sum}
//  busy            out  1        high while a run is active
//  done            out  1        high from run end until next accepted start or reset
//  pass            out  1        valid while done: 1 iff err_count==0
//  err_count       out  CNT_W    mismatches this run; saturates at all-ones
//  first_fail_a    out  WIDTH    A of the first mismatching vector
//  first_fail_b    out  WIDTH    B of the first mismatching vector
//  first_fail_cin  out  1        CIN of the first mismatching vector
//  first_fail_sum  out  WIDTH+1  SUM observed for the first mismatching vector
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE. All outputs 0, LFSR=SEED, all counters 0.
//    Reset aborts any run at any point. The next cycle is IDLE.
//  - FSM states: IDLE -> DRIVE -> SETTLE -> CHECK -> (DRIVE | DONE); DONE -> DRIVE on start.
//    * IDLE/DONE + start:
//      - Latch num_vectors. Clear err_count, the first_fail_* registers, and the vector index.
//      - Reload LFSR=SEED. Clear done.
//      - If num_vectors==0: go directly to DONE, with pass=1, one cycle after start.
//      - Otherwise go to DRIVE; busy=1 from the next cycle.
//    * DRIVE (1 cycle): register dut_a/b/cin from the vector source. Register the golden value
//      exp = {1'b0,A}+{1'b0,B}+CIN, which is WIDTH+1 bits with no truncation.
//    * SETTLE: stay exactly SETTLE_CYCLES cycles; operands are held stable.
//    * CHECK (1 cycle): compare dut_sum to exp.
//      - On mismatch: err_count increments, saturating.
//      - If err_count was 0 before the increment: capture first_fail_* from the driven vector and dut_sum.
//      - Then increment the vector index. If it equals num_vectors: go to DONE, else go to DRIVE.
//    * DONE: busy=0, done=1, pass=(err_count==0). dut_* hold their last values.
//  - Per-vector latency is SETTLE_CYCLES+2 cycles. done rises N*(SETTLE_CYCLES+2)+1 cycles after
//    start is accepted, for N>0.
//  - start while busy is ignored. Mismatches never stop the run.
//  - Vector source:
//    * Index 0: A=all-ones, B=0, CIN=1 (full carry ripple into the MSB).
//    * Index 1: A=all-ones, B=all-ones, CIN=1.
//    * Index 2: A=0, B=0, CIN=0.
//    * Index >=3: the LFSR advances one step per DRIVE. A=lfsr[WIDTH-1:0], B=lfsr[2*WIDTH-1:WIDTH],
//      CIN=lfsr[31].
//  - LFSR is a 32-bit Galois LFSR with taps x^32+x^22+x^2+x+1. It never reaches 0.
//  - The vector index wraps only via num_vectors; the max run is 2^CNT_W-1 vectors.
// STRUCTURE
//  - Package adder_chk_pkg: typedef of the state enum (IDLE, DRIVE, SETTLE, CHECK, DONE),
//    the LFSR_TAPS constant, and the corner-vector constants.
//  - Sub-module adder_chk_lfsr (32-bit Galois LFSR): inputs clk, rst_n, load, seed, step;
//    output value. All else is inline FSM and datapath.
// TESTING
//  1. Correct 8-bit adder model, num_vectors=100, start -> done after 401 cycles, pass=1, err_count=0.
//  2. Adder with its MSB cell forcing sum[7] inverted, num_vectors=3 -> err_count=3, pass=0,
//     first_fail_a=8'hFF, first_fail_b=8'h00, first_fail_cin=1, first_fail_sum=9'h180.
//  3. num_vectors=0, start -> done=1 and pass=1 in the following cycle; busy never asserts.
//  4. start pulsed in DRIVE/SETTLE/CHECK mid-run -> ignored; vector count and done timing unchanged.
//  5. rst_n=0 during SETTLE of vector 5, then start -> all outputs 0 after reset, and the new run
//     replays vectors 0,1,2 and the same LFSR sequence.
//  6. CNT_W=4 with an always-wrong adder, num_vectors=15 -> err_count saturates at 4'hF;
//     first_fail_* is captured from vector 0.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// Package: adder_chk_pkg
// Shared types and constants for the adder vector checker.
//   state_t      - checker FSM states
//   LFSR_TAPS    - Galois feedback mask for x^32+x^22+x^2+x+1 (right-shifting form)
//   corner_t     - fixed corner-vector description (operands all-ones or all-zeros)
//   CORNER_0..2  - vectors driven at indices 0, 1, 2 ahead of the LFSR sequence
package adder_chk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef struct packed {
      logic a_ones;
      logic b_ones;
      logic cin;
   } corner_t;

   // Full carry ripple into the MSB.
   localparam corner_t CORNER_0 = '{a_ones: 1'b1, b_ones: 1'b0, cin: 1'b1};
   // Maximum sum, every cell generates and propagates.
   localparam corner_t CORNER_1 = '{a_ones: 1'b1, b_ones: 1'b1, cin: 1'b1};
   // All zero.
   localparam corner_t CORNER_2 = '{a_ones: 1'b0, b_ones: 1'b0, cin: 1'b0};

   localparam int unsigned NUM_CORNERS = 3;

endpackage

// File: rtl/adder_chk_lfsr.sv
// Module: adder_chk_lfsr
// 32-bit Galois LFSR supplying pseudo-random operands.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset, loads seed
//   load   in   restart from seed (has priority over step)
//   seed   in   32-bit nonzero seed
//   step   in   advance one state
//   value  out  current LFSR state
module adder_chk_lfsr
   import adder_chk_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] value
);

   always_ff @(posedge clk) begin
      if (!rst_n || load) begin
         value <= seed;
      end else if (step) begin
         value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
      end
   end

endmodule

// File: rtl/adder_vector_checker.sv
// Module: adder_vector_checker
// Hardware self-test initiator for an external WIDTH-bit ripple-carry adder.
// Drives operand vectors, waits SETTLE_CYCLES, compares the returned sum with
// A+B+CIN, counts mismatches and records the first failing vector.
//   clk, rst_n                 clock, synchronous active-low reset
//   start, num_vectors         begin a run of num_vectors vectors (IDLE/DONE only)
//   dut_a, dut_b, dut_cin      operands to the adder
//   dut_sum                    adder result {cout, sum}
//   busy, done, pass           run status; pass valid while done
//   err_count                  saturating mismatch count for this run
//   first_fail_a/b/cin/sum     first mismatching vector and observed sum
module adder_vector_checker
   import adder_chk_pkg::*;
#(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16,
   parameter logic [31:0] SEED          = 32'hACE1_1234
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_vectors,
   output logic [WIDTH-1:0]  dut_a,
   output logic [WIDTH-1:0]  dut_b,
   output logic              dut_cin,
   input  logic [WIDTH:0]    dut_sum,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [WIDTH-1:0]  first_fail_a,
   output logic [WIDTH-1:0]  first_fail_b,
   output logic              first_fail_cin,
   output logic [WIDTH:0]    first_fail_sum
);

   localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   num_lat;
   logic [CNT_W-1:0]   vec_idx;
   logic [CNT_W-1:0]   idx_inc;
   logic [SC_W-1:0]    settle_cnt;
   logic [WIDTH:0]     exp_sum;
   logic [31:0]        lfsr;
   logic               accept;
   logic               is_corner;
   corner_t            corner;
   logic [WIDTH-1:0]   vec_a, vec_b;
   logic               vec_cin;
   logic               lfsr_unused;

   assign accept      = start && ((state == IDLE) || (state == DONE));
   assign idx_inc     = vec_idx + CNT_W'(1);
   assign is_corner   = vec_idx < CNT_W'(NUM_CORNERS);
   assign lfsr_unused = ^lfsr[30:2*WIDTH];

   adder_chk_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .seed  (SEED),
      .step  ((state == DRIVE) && !is_corner),
      .value (lfsr)
   );

   // Vector source: three fixed corners, then the LFSR value before it steps.
   always_comb begin
      corner = CORNER_2;
      if (vec_idx == CNT_W'(0))      corner = CORNER_0;
      else if (vec_idx == CNT_W'(1)) corner = CORNER_1;
      vec_a   = lfsr[WIDTH-1:0];
      vec_b   = lfsr[2*WIDTH-1:WIDTH];
      vec_cin = lfsr[31];
      if (is_corner) begin
         vec_a   = {WIDTH{corner.a_ones}};
         vec_b   = {WIDTH{corner.b_ones}};
         vec_cin = corner.cin;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: if (start) state_nx = (num_vectors == '0) ? DONE : DRIVE;
         DRIVE:      state_nx = SETTLE;
         SETTLE:     if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_nx = CHECK;
         CHECK:      state_nx = (idx_inc == num_lat) ? DONE : DRIVE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
      done = (state == DONE);
      pass = (state == DONE) && (err_count == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num_lat        <= '0;
         vec_idx        <= '0;
         settle_cnt     <= '0;
         exp_sum        <= '0;
         dut_a          <= '0;
         dut_b          <= '0;
         dut_cin        <= 1'b0;
         err_count      <= '0;
         first_fail_a   <= '0;
         first_fail_b   <= '0;
         first_fail_cin <= 1'b0;
         first_fail_sum <= '0;
      end else begin
         if (accept) begin
            num_lat        <= num_vectors;
            vec_idx        <= '0;
            err_count      <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
            first_fail_sum <= '0;
         end

         settle_cnt <= (state == SETTLE) ? settle_cnt + SC_W'(1) : '0;

         if (state == DRIVE) begin
            dut_a   <= vec_a;
            dut_b   <= vec_b;
            dut_cin <= vec_cin;
            exp_sum <= {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
         end

         if (state == CHECK) begin
            vec_idx <= idx_inc;
            if (dut_sum != exp_sum) begin
               if (err_count != '1) err_count <= err_count + CNT_W'(1);
               if (err_count == '0) begin
                  first_fail_a   <= dut_a;
                  first_fail_b   <= dut_b;
                  first_fail_cin <= dut_cin;
                  first_fail_sum <= dut_sum;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_vector_checker.sv
// Testbench: tb_adder_vector_checker
// Scoreboard bench: each run pushes its expected outcome; monitors pop and
// compare when done rises. One 8-bit/16-bit-count checker beside a behavioural
// adder with an optional MSB fault, one 4-bit-count checker beside an
// always-wrong adder.
module tb_adder_vector_checker;

   localparam int unsigned W = 8;
   localparam int unsigned S = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start0, start4, fault;
   logic [15:0] nv0;
   logic [3:0]  nv4;

   logic [7:0]  a0, b0, ffa0, ffb0, a4, b4, ffa4, ffb4;
   logic        cin0, ffc0, cin4, ffc4;
   logic [8:0]  sum0, ffs0, sum4, ffs4;
   logic        busy0, done0, pass0, busy4, done4, pass4;
   logic [15:0] err0;
   logic [3:0]  err4;

   always_comb begin
      sum0 = {1'b0, a0} + {1'b0, b0} + {8'd0, cin0};
      if (fault) sum0[7] = ~sum0[7];
   end
   assign sum4 = {1'b0, a4} + {1'b0, b4} + {8'd0, cin4} + 9'd1;

   adder_vector_checker #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(16), .SEED(32'hACE1_1234)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .num_vectors(nv0),
      .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_cin(ffc0), .first_fail_sum(ffs0));

   adder_vector_checker #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(4), .SEED(32'hACE1_1234)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .num_vectors(nv4),
      .dut_a(a4), .dut_b(b4), .dut_cin(cin4), .dut_sum(sum4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .first_fail_a(ffa4), .first_fail_b(ffb4), .first_fail_cin(ffc4), .first_fail_sum(ffs4));

   typedef struct {
      int          lat;
      logic        pass;
      logic [15:0] err;
      logic [7:0]  fa;
      logic [7:0]  fb;
      logic        fc;
      logic [8:0]  fs;
   } exp_t;

   exp_t q0[$];
   exp_t q4[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   st0 = 0;
   int   st4 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int lat, input logic p, input logic [15:0] e,
                               input logic [7:0] fa, input logic [7:0] fb,
                               input logic fc, input logic [8:0] fs);
      exp_t r;
      r.lat = lat; r.pass = p; r.err = e; r.fa = fa; r.fb = fb; r.fc = fc; r.fs = fs;
      return r;
   endfunction

   // Monitor for the 16-bit-count checker.
   initial begin : mon0
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done0 && !prev) begin
            chk("done0_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("lat0", cyc - st0 + 1, e.lat);
               chk("pass0", pass0, e.pass);
               chk("err0", err0, e.err);
               chk("ff_a0", ffa0, e.fa);
               chk("ff_b0", ffb0, e.fb);
               chk("ff_cin0", ffc0, e.fc);
               chk("ff_sum0", ffs0, e.fs);
            end
         end
         prev = done0;
      end
   end

   // Monitor for the 4-bit-count checker.
   initial begin : mon4
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (done4 && !prev) begin
            chk("done4_expected", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
               e = q4.pop_front();
               chk("lat4", cyc - st4 + 1, e.lat);
               chk("pass4", pass4, e.pass);
               chk("err4", {12'd0, err4}, e.err);
               chk("ff_a4", ffa4, e.fa);
               chk("ff_b4", ffb4, e.fb);
               chk("ff_cin4", ffc4, e.fc);
               chk("ff_sum4", ffs4, e.fs);
            end
         end
         prev = done4;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run0(input int n, input exp_t e);
      start0 = 1'b1;
      nv0    = n[15:0];
      tick();
      start0 = 1'b0;
      st0    = cyc;
      q0.push_back(e);
   endtask

   task automatic wait_done0(input int limit);
      int k = 0;
      while (!done0 && k < limit) begin
         tick();
         k++;
      end
      if (!done0) chk("timeout0", done0, 1);
      tick();
   endtask

   task automatic capture6(output logic [16:0] v [6]);
      tick();
      v[0] = {a0, b0, cin0};
      for (int k = 1; k < 6; k++) begin
         repeat (S + 2) tick();
         v[k] = {a0, b0, cin0};
      end
   endtask

   logic [16:0] va [6];
   logic [16:0] vb [6];
   logic [16:0] vref [6];
   logic        busy_seen;

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start4 = 1'b0; nv0 = '0; nv4 = '0; fault = 1'b0;
      vref[0] = {8'hFF, 8'h00, 1'b1};
      vref[1] = {8'hFF, 8'hFF, 1'b1};
      vref[2] = {8'h00, 8'h00, 1'b0};
      vref[3] = {8'h34, 8'h12, 1'b1};
      vref[4] = {8'h1A, 8'h89, 1'b0};
      vref[5] = {8'h8D, 8'h44, 1'b0};
      repeat (3) tick();

      // Reset state
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_pass", pass0, 0);
      chk("rst_err", err0, 0);
      chk("rst_ops", {a0, b0, cin0}, 0);
      chk("rst_ff", {ffa0, ffb0, ffc0, ffs0}, 0);
      chk("rst_err4", err4, 0);
      rst_n = 1'b1;
      tick();

      // Zero-length run from IDLE: done next cycle, busy never
      run0(0, mk(1, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0, 9'h000));
      busy_seen = busy0;
      repeat (3) begin
         tick();
         busy_seen = busy_seen | busy0;
      end
      chk("t3_busy_never", busy_seen, 0);

      // Correct adder, 100 vectors
      run0(100, mk(401, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0, 9'h000));
      wait_done0(500);

      // MSB sum bit inverted, 3 vectors
      fault = 1'b1;
      run0(3, mk(13, 1'b0, 16'd3, 8'hFF, 8'h00, 1'b1, 9'h180));
      wait_done0(50);
      fault = 1'b0;

      // Zero-length run from DONE clears the previous failure record
      start0 = 1'b1; nv0 = '0;
      tick();
      start0 = 1'b0;
      tick();
      chk("t3b_done", done0, 1);
      chk("t3b_busy", busy0, 0);
      chk("t3b_pass", pass0, 1);
      chk("t3b_err", err0, 0);
      chk("t3b_ff", {ffa0, ffb0, ffc0, ffs0}, 0);

      // Start pulses during DRIVE, SETTLE and CHECK are ignored
      run0(5, mk(21, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0, 9'h000));
      nv0 = 16'd2;
      start0 = 1'b1; tick();
      start0 = 1'b0; tick();
      start0 = 1'b1; tick();
      tick();
      start0 = 1'b0;
      wait_done0(50);

      // Reset in SETTLE of vector 5, then replay
      start0 = 1'b1; nv0 = 16'd10;
      tick();
      start0 = 1'b0;
      capture6(va);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("t5_rst_busy", busy0, 0);
      chk("t5_rst_done", done0, 0);
      chk("t5_rst_ops", {a0, b0, cin0}, 0);
      chk("t5_rst_err", err0, 0);
      run0(6, mk(25, 1'b1, 16'd0, 8'h00, 8'h00, 1'b0, 9'h000));
      capture6(vb);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("t5_vec%0d_first", k), va[k], vref[k]);
         chk($sformatf("t5_vec%0d_replay", k), vb[k], va[k]);
      end
      wait_done0(50);

      // Narrow counters against an always-wrong adder
      start4 = 1'b1; nv4 = 4'd15;
      tick();
      start4 = 1'b0;
      st4 = cyc;
      q4.push_back(mk(61, 1'b0, 16'h000F, 8'hFF, 8'h00, 1'b1, 9'h101));
      begin
         int k = 0;
         while (!done4 && k < 200) begin
            tick();
            k++;
         end
         if (!done4) chk("timeout4", done4, 1);
      end
      tick();

      chk("q0_drained", q0.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
